bp_me_axi_manager: RTL

- Converts BedRock Stream mem_fwd messages into AXI4 manager transactions, and AXI responses back into BedRock Stream mem_rev messages.
- It is the initiating counterpart of the AXI-to-BedRock subordinate bridge. It sits at the edge of a BP tile or I/O complex and drives an external AXI4 subordinate such as DRAM or a peripheral crossbar.
- It handles one transaction in flight at a time, which gives strict request order.

---
 rtl/bp_me_axi_pkg.sv | 101 ++++++++++
 rtl/bp_me_axi_manager.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bp_me_axi_pkg.sv
// Shared types for the BedRock-to-AXI manager bridge: message header layout,
// AXI encodings, bridge states and the size-to-AXI translation helpers.
package bp_me_axi_pkg;

    localparam int unsigned paddr_width_lp    = 40;
    localparam int unsigned payload_width_lp  = 16;
    localparam int unsigned beat_cnt_width_lp = 4;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_lp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_lp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    localparam int unsigned mem_header_width_lp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_e;

    localparam logic [1:0] axi_burst_fixed = 2'b00;
    localparam logic [1:0] axi_burst_incr  = 2'b01;
    localparam logic [1:0] axi_burst_wrap  = 2'b10;

    typedef enum logic [2:0] {
        e_ready,
        e_write,
        e_wait_b,
        e_write_rsp,
        e_read_req,
        e_read_data
    } bridge_state_e;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [7:0] strb;
    } axi_xlate_s;

    // Sub-word requests are forced onto their natural alignment.
    function automatic logic [paddr_width_lp-1:0] align_addr(
        input logic [paddr_width_lp-1:0] addr,
        input bp_bedrock_msg_size_e      size
    );
        logic [paddr_width_lp-1:0] a;
        a = addr;
        case (size)
            e_bedrock_msg_size_2: a[0]   = 1'b0;
            e_bedrock_msg_size_4: a[1:0] = 2'b00;
            default: ;
        endcase
        return a;
    endfunction

    function automatic axi_xlate_s axi_xlate(
        input bp_bedrock_msg_size_e size,
        input logic [2:0]           offset
    );
        axi_xlate_s x;
        x.len  = 8'd0;
        x.size = 3'd3;
        x.strb = 8'hFF;
        case (size)
            e_bedrock_msg_size_1:   begin x.size = 3'd0; x.strb = 8'h01 << offset; end
            e_bedrock_msg_size_2:   begin x.size = 3'd1; x.strb = 8'h03 << offset; end
            e_bedrock_msg_size_4:   begin x.size = 3'd2; x.strb = 8'h0F << offset; end
            e_bedrock_msg_size_16:  x.len = 8'd1;
            e_bedrock_msg_size_32:  x.len = 8'd3;
            e_bedrock_msg_size_64:  x.len = 8'd7;
            e_bedrock_msg_size_128: x.len = 8'd15;
            default: ;
        endcase
        return x;
    endfunction

endpackage

// File: rtl/bp_me_axi_manager.sv
// BedRock Stream mem_fwd to AXI4 manager bridge; one transaction in flight,
// responses returned as mem_rev beats with a sticky error flag.
module bp_me_axi_manager
    import bp_me_axi_pkg::*;
#(
    parameter int unsigned m_axi_data_width_p = 64,
    parameter int unsigned m_axi_addr_width_p = 64,
    parameter int unsigned m_axi_id_width_p   = 1
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [mem_header_width_lp-1:0]  mem_fwd_header_i,
    input  logic [m_axi_data_width_p-1:0]   mem_fwd_data_i,
    input  logic                            mem_fwd_v_i,
    output logic                            mem_fwd_ready_and_o,
    output logic [mem_header_width_lp-1:0]  mem_rev_header_o,
    output logic [m_axi_data_width_p-1:0]   mem_rev_data_o,
    output logic                            mem_rev_v_o,
    input  logic                            mem_rev_ready_and_i,
    output logic [m_axi_addr_width_p-1:0]   m_axi_awaddr_o,
    output logic                            m_axi_awvalid_o,
    output logic [m_axi_id_width_p-1:0]     m_axi_awid_o,
    output logic [7:0]                      m_axi_awlen_o,
    output logic [2:0]                      m_axi_awsize_o,
    output logic [1:0]                      m_axi_awburst_o,
    output logic                            m_axi_awlock_o,
    output logic [3:0]                      m_axi_awcache_o,
    output logic [2:0]                      m_axi_awprot_o,
    output logic [3:0]                      m_axi_awqos_o,
    output logic [3:0]                      m_axi_awregion_o,
    input  logic                            m_axi_awready_i,
    output logic [m_axi_data_width_p-1:0]   m_axi_wdata_o,
    output logic [m_axi_data_width_p/8-1:0] m_axi_wstrb_o,
    output logic                            m_axi_wlast_o,
    output logic                            m_axi_wvalid_o,
    input  logic                            m_axi_wready_i,
    input  logic                            m_axi_bvalid_i,
    input  logic [m_axi_id_width_p-1:0]     m_axi_bid_i,
    input  logic [1:0]                      m_axi_bresp_i,
    output logic                            m_axi_bready_o,
    output logic [m_axi_addr_width_p-1:0]   m_axi_araddr_o,
    output logic                            m_axi_arvalid_o,
    output logic [m_axi_id_width_p-1:0]     m_axi_arid_o,
    output logic [7:0]                      m_axi_arlen_o,
    output logic [2:0]                      m_axi_arsize_o,
    output logic [1:0]                      m_axi_arburst_o,
    output logic                            m_axi_arlock_o,
    output logic [3:0]                      m_axi_arcache_o,
    output logic [2:0]                      m_axi_arprot_o,
    output logic [3:0]                      m_axi_arqos_o,
    output logic [3:0]                      m_axi_arregion_o,
    input  logic                            m_axi_arready_i,
    input  logic [m_axi_data_width_p-1:0]   m_axi_rdata_i,
    input  logic                            m_axi_rvalid_i,
    input  logic [m_axi_id_width_p-1:0]     m_axi_rid_i,
    input  logic                            m_axi_rlast_i,
    input  logic [1:0]                      m_axi_rresp_i,
    output logic                            m_axi_rready_o,
    output logic                            error_o
);

    localparam int unsigned strb_width_lp = m_axi_data_width_p / 8;

    bridge_state_e                 state_q;
    bp_bedrock_mem_header_s        hdr_q;
    bp_bedrock_mem_header_s        fwd_hdr;
    logic [beat_cnt_width_lp-1:0]  cnt_q;
    logic                          aw_done_q, w_done_q, error_q;
    logic [paddr_width_lp-1:0]     ax_addr;
    axi_xlate_s                    xl;
    logic                          aw_fire, w_fire, w_last, b_fire, ar_fire, r_fire;
    logic                          unused_ids;

    assign fwd_hdr    = bp_bedrock_mem_header_s'(mem_fwd_header_i);
    assign ax_addr    = align_addr(hdr_q.addr, hdr_q.size);
    assign xl         = axi_xlate(hdr_q.size, ax_addr[2:0]);
    assign w_last     = (cnt_q == xl.len[beat_cnt_width_lp-1:0]);
    assign unused_ids = ^{m_axi_bid_i, m_axi_rid_i};

    assign aw_fire = m_axi_awvalid_o & m_axi_awready_i;
    assign w_fire  = m_axi_wvalid_o  & m_axi_wready_i;
    assign b_fire  = m_axi_bvalid_i  & m_axi_bready_o;
    assign ar_fire = m_axi_arvalid_o & m_axi_arready_i;
    assign r_fire  = m_axi_rvalid_i  & m_axi_rready_o;

    // Bridge FSM: header capture, AW/W/B or AR/R sequencing, sticky error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_ready;
            hdr_q     <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                e_ready: if (mem_fwd_v_i) begin
                    hdr_q     <= fwd_hdr;
                    cnt_q     <= '0;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    state_q   <= (fwd_hdr.msg_type inside {e_bedrock_mem_uc_wr, e_bedrock_mem_wr})
                                 ? e_write : e_read_req;
                end
                e_write: begin
                    if (aw_fire) aw_done_q <= 1'b1;
                    if (w_fire) begin
                        cnt_q <= cnt_q + beat_cnt_width_lp'(1);
                        if (w_last) w_done_q <= 1'b1;
                    end
                    if ((aw_done_q | aw_fire) && (w_done_q | (w_fire & w_last))) begin
                        cnt_q   <= '0;
                        state_q <= e_wait_b;
                    end
                end
                e_wait_b: if (b_fire) begin
                    if (m_axi_bresp_i != e_axi_resp_okay) error_q <= 1'b1;
                    state_q <= e_write_rsp;
                end
                e_write_rsp: if (mem_rev_ready_and_i) state_q <= e_ready;
                e_read_req: if (ar_fire) begin
                    cnt_q   <= '0;
                    state_q <= e_read_data;
                end
                e_read_data: if (r_fire) begin
                    cnt_q <= cnt_q + beat_cnt_width_lp'(1);
                    // A short burst (rlast before the expected beat) is flagged as an error.
                    if ((m_axi_rresp_i != e_axi_resp_okay) ||
                        (m_axi_rlast_i && (cnt_q != xl.len[beat_cnt_width_lp-1:0])))
                        error_q <= 1'b1;
                    if (m_axi_rlast_i) state_q <= e_ready;
                end
                default: state_q <= e_ready;
            endcase
        end
    end

    // Handshake decode; W and R are zero-latency pass-throughs.
    always_comb begin
        mem_fwd_ready_and_o = 1'b0;
        mem_rev_v_o         = 1'b0;
        mem_rev_data_o      = '0;
        m_axi_awvalid_o     = 1'b0;
        m_axi_wvalid_o      = 1'b0;
        m_axi_bready_o      = 1'b0;
        m_axi_arvalid_o     = 1'b0;
        m_axi_rready_o      = 1'b0;
        case (state_q)
            e_write: begin
                m_axi_awvalid_o     = ~aw_done_q;
                m_axi_wvalid_o      = mem_fwd_v_i & ~w_done_q;
                mem_fwd_ready_and_o = m_axi_wready_i & ~w_done_q;
            end
            e_wait_b:    m_axi_bready_o = 1'b1;
            e_write_rsp: mem_rev_v_o    = 1'b1;
            e_read_req: begin
                m_axi_arvalid_o     = 1'b1;
                mem_fwd_ready_and_o = m_axi_arready_i;
            end
            e_read_data: begin
                mem_rev_v_o    = m_axi_rvalid_i;
                m_axi_rready_o = mem_rev_ready_and_i;
                mem_rev_data_o = m_axi_rdata_i;
            end
            default: ;
        endcase
    end

    assign mem_rev_header_o = hdr_q;
    assign error_o          = error_q;

    assign m_axi_awaddr_o   = m_axi_addr_width_p'(ax_addr);
    assign m_axi_awid_o     = '0;
    assign m_axi_awlen_o    = xl.len;
    assign m_axi_awsize_o   = xl.size;
    assign m_axi_awburst_o  = axi_burst_incr;
    assign m_axi_awlock_o   = 1'b0;
    assign m_axi_awcache_o  = 4'b0011;
    assign m_axi_awprot_o   = '0;
    assign m_axi_awqos_o    = '0;
    assign m_axi_awregion_o = '0;

    assign m_axi_wdata_o    = mem_fwd_data_i;
    assign m_axi_wstrb_o    = strb_width_lp'(xl.strb);
    assign m_axi_wlast_o    = w_last;

    assign m_axi_araddr_o   = m_axi_addr_width_p'(ax_addr);
    assign m_axi_arid_o     = '0;
    assign m_axi_arlen_o    = xl.len;
    assign m_axi_arsize_o   = xl.size;
    assign m_axi_arburst_o  = axi_burst_incr;
    assign m_axi_arlock_o   = 1'b0;
    assign m_axi_arcache_o  = 4'b0011;
    assign m_axi_arprot_o   = '0;
    assign m_axi_arqos_o    = '0;
    assign m_axi_arregion_o = '0;

endmodule
